// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: the
// XAPP052 table-3 tap masks, the legal LFSR width range and the
// checker state encoding.
package prbs_pkg;

  localparam int DATA_MIN = 3;
  localparam int DATA_MAX = 16;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbsState_t;

  // Tap positions are stored as a bit mask over state[15:0]; tap n of
  // the table maps to bit n-1 of the shift register.
  function automatic logic [15:0] tapMask(input int width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/prbs_feedback.sv
// Combinational LFSR feedback: XOR of the tapped state bits. Shared by
// the generator and the checker so both ends use one tap table.
module prbs_feedback
  import prbs_pkg::*;
#(
  parameter int DATA = 3
) (
  input  logic [DATA-1:0] i_state,
  output logic            o_fb
);

  localparam logic [DATA-1:0] TAP_MASK = DATA'(tapMask(DATA));

  assign o_fb = ^(i_state & TAP_MASK);

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds a local LFSR from the received stream,
// verifies LOCK_LEN predictions, then free-runs and counts mismatches.
// Optional macro PRBS_CHK_RESYNC_EN adds windowed loss-of-lock detection.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int DATA     = 3,
  parameter int LOCK_LEN = 8,
  parameter int ERR_W    = 16,
  parameter int WIN_LEN  = 64,
  parameter int ERR_THR  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr,
  output logic             lock,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int SEED_W = $clog2(DATA);
  localparam int RUN_W  = $clog2(LOCK_LEN + 1);

  if (DATA < DATA_MIN || DATA > DATA_MAX) begin : g_badData
    $fatal(1, "prbs_checker: DATA must be within 3..16");
  end
  if (LOCK_LEN < 1) begin : g_badLockLen
    $fatal(1, "prbs_checker: LOCK_LEN must be at least 1");
  end
  if (ERR_THR < 1 || ERR_THR > WIN_LEN) begin : g_badErrThr
    $fatal(1, "prbs_checker: ERR_THR must be within 1..WIN_LEN");
  end

  prbsState_t        r_state, w_nextState;
  logic [DATA-1:0]   r_sr, w_srNext;
  logic [SEED_W-1:0] r_seedCnt, w_seedCntNext;
  logic [RUN_W-1:0]  r_runCnt, w_runCntNext;
  logic              r_lock, r_err;
  logic [ERR_W-1:0]  r_errCnt, w_errCntNext;
  logic              w_pred, w_mismatch, w_lockedMiss, w_resync;

  prbs_feedback #(.DATA(DATA)) u_feedback (
    .i_state (r_sr),
    .o_fb    (w_pred)
  );

  assign w_mismatch   = in_bit ^ w_pred;
  assign w_lockedMiss = in_valid && (r_state == LOCKED) && w_mismatch;

`ifdef PRBS_CHK_RESYNC_EN
  localparam int WC_W = $clog2(WIN_LEN + 1);
  localparam int WE_W = $clog2(ERR_THR + 1);

  logic [WC_W-1:0] r_winCnt;
  logic [WE_W-1:0] r_winErr;

  // The window error count never exceeds ERR_THR-1, so the next locked
  // mismatch at that level is the one that crosses the threshold.
  assign w_resync = w_lockedMiss && (r_winErr == WE_W'(ERR_THR - 1));

  // Window position and window mismatch count, live only while LOCKED.
  always_ff @(posedge clk) begin
    if (!reset || (r_state != LOCKED) || w_resync) begin
      r_winCnt <= '0;
      r_winErr <= '0;
    end else if (in_valid) begin
      if (r_winCnt == WC_W'(WIN_LEN - 1)) begin
        r_winCnt <= '0;
        r_winErr <= '0;
      end else begin
        r_winCnt <= r_winCnt + WC_W'(1);
        r_winErr <= r_winErr + WE_W'(w_lockedMiss);
      end
    end
  end
`else
  assign w_resync = 1'b0;
`endif

  // Next-state, shift register and seed/run counter update per valid bit.
  always_comb begin
    w_nextState   = r_state;
    w_srNext      = r_sr;
    w_seedCntNext = r_seedCnt;
    w_runCntNext  = r_runCnt;
    if (in_valid) begin
      case (r_state)
        SEED: begin
          w_srNext = {r_sr[DATA-2:0], in_bit};
          if (r_seedCnt == SEED_W'(DATA - 1)) begin
            w_seedCntNext = '0;
            if (w_srNext != '0) begin
              w_nextState  = VERIFY;
              w_runCntNext = '0;
            end
          end else begin
            w_seedCntNext = r_seedCnt + SEED_W'(1);
          end
        end
        VERIFY: begin
          if (!w_mismatch) begin
            w_srNext = {r_sr[DATA-2:0], w_pred};
            if (r_runCnt == RUN_W'(LOCK_LEN - 1)) begin
              w_nextState  = LOCKED;
              w_runCntNext = '0;
            end else begin
              w_runCntNext = r_runCnt + RUN_W'(1);
            end
          end else begin
            w_nextState   = SEED;
            w_seedCntNext = '0;
          end
        end
        LOCKED: begin
          w_srNext = {r_sr[DATA-2:0], w_pred};
          if (w_resync) begin
            w_nextState   = SEED;
            w_seedCntNext = '0;
          end
        end
        default: begin
          w_nextState   = SEED;
          w_seedCntNext = '0;
        end
      endcase
    end
  end

  // Saturating error count; a clear in the same cycle as a mismatch wins.
  always_comb begin
    w_errCntNext = r_errCnt;
    if (w_lockedMiss && (r_errCnt != '1)) begin
      w_errCntNext = r_errCnt + ERR_W'(1);
    end
    if (clr) begin
      w_errCntNext = '0;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= SEED;
      r_sr      <= '0;
      r_seedCnt <= '0;
      r_runCnt  <= '0;
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
      r_errCnt  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_sr      <= w_srNext;
      r_seedCnt <= w_seedCntNext;
      r_runCnt  <= w_runCntNext;
      r_lock    <= (w_nextState == LOCKED);
      r_err     <= w_lockedMiss;
      r_errCnt  <= w_errCntNext;
    end
  end

  assign lock    = r_lock;
  assign err     = r_err;
  assign err_cnt = r_errCnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker (DATA=7, LOCK_LEN=8, WIN_LEN=64,
// ERR_THR=8) with two instances differing only in err_cnt width.
module tb_prbs_checker;

  localparam int D        = 7;
  localparam int LL       = 8;
  localparam int WIN      = 64;
  localparam int THR      = 8;
  localparam int SR_MASK  = (1 << D) - 1;
  localparam int POLY     = (1 << 6) | (1 << 5);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr = 1'b0;
  logic        lockA, errA, lockB, errB;
  logic [15:0] cntA;
  logic [3:0]  cntB;

  int checks = 0;
  int failures = 0;

  int genSr;
  int mMode, mFill, mSr, mRun, mWinPos, mWinErr, mTotal;
  bit mErr, mLock;

  prbs_checker #(.DATA(D), .LOCK_LEN(LL), .ERR_W(16), .WIN_LEN(WIN), .ERR_THR(THR)) dutA (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clr(clr),
    .lock(lockA), .err(errA), .err_cnt(cntA)
  );

  prbs_checker #(.DATA(D), .LOCK_LEN(LL), .ERR_W(4), .WIN_LEN(WIN), .ERR_THR(THR)) dutB (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clr(clr),
    .lock(lockB), .err(errB), .err_cnt(cntB)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int parity(input int v);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  function automatic bit genStep();
    int fb;
    fb = parity(genSr & POLY);
    genSr = ((genSr << 1) | fb) & SR_MASK;
    return bit'(fb);
  endfunction

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelUpdate(input bit rstN, input bit v, input bit b, input bit c);
    int p;
    if (!rstN) begin
      mMode = 0; mFill = 0; mSr = 0; mRun = 0;
      mWinPos = 0; mWinErr = 0; mTotal = 0;
      mErr = 0; mLock = 0;
    end else begin
      mErr = 0;
      if (v) begin
        if (mMode == 0) begin
          mSr = ((mSr << 1) | int'(b)) & SR_MASK;
          mFill++;
          if (mFill == D) begin
            mFill = 0;
            if (mSr != 0) begin mMode = 1; mRun = 0; end
          end
        end else if (mMode == 1) begin
          p = parity(mSr & POLY);
          if (int'(b) == p) begin
            mSr = ((mSr << 1) | p) & SR_MASK;
            mRun++;
            if (mRun == LL) begin mMode = 2; mWinPos = 0; mWinErr = 0; end
          end else begin
            mMode = 0; mFill = 0;
          end
        end else begin
          p = parity(mSr & POLY);
          mSr = ((mSr << 1) | p) & SR_MASK;
          if (int'(b) != p) begin mErr = 1; mTotal++; mWinErr++; end
          mWinPos++;
`ifdef PRBS_CHK_RESYNC_EN
          if (mWinErr >= THR) begin
            mMode = 0; mFill = 0;
          end else if (mWinPos == WIN) begin
            mWinPos = 0; mWinErr = 0;
          end
`else
          if (mWinPos == WIN) begin mWinPos = 0; mWinErr = 0; end
`endif
        end
      end
      if (c) mTotal = 0;
      mLock = (mMode == 2);
    end
  endtask

  task automatic checkOutput();
    checkValue("lockA", 32'(lockA), 32'(mLock));
    checkValue("errA", 32'(errA), 32'(mErr));
    checkValue("errCntA", 32'(cntA), 32'(minInt(mTotal, 65535)));
    checkValue("lockB", 32'(lockB), 32'(mLock));
    checkValue("errB", 32'(errB), 32'(mErr));
    checkValue("errCntB", 32'(cntB), 32'(minInt(mTotal, 15)));
  endtask

  task automatic applyStimulus(input bit rstN, input bit v, input bit b, input bit c);
    @(negedge clk);
    reset = rstN; in_valid = v; in_bit = b; clr = c;
    @(posedge clk);
    modelUpdate(rstN, v, b, c);
    #1;
    checkOutput();
  endtask

  task automatic streamBit(input bit flip, input bit c);
    bit b;
    b = genStep() ^ flip;
    applyStimulus(1'b1, 1'b1, b, c);
  endtask

  task automatic lockUp(output int n);
    applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0);
    n = 0;
    do begin
      streamBit(1'b0, 1'b0);
      n++;
    end while (!lockA && n < 60);
  endtask

  initial begin
    int n;
    bit v, b, c, r;
    genSr = $urandom_range(1, SR_MASK);
    modelUpdate(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset held with random valid bits");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0);
      checkValue("resetLock", 32'(lockA), 32'd0);
      checkValue("resetErr", 32'(errA), 32'd0);
      checkValue("resetErrCnt", 32'(cntA), 32'd0);
    end

    $display("[TB] clean stream lock latency and long run");
    lockUp(n);
    checkValue("lockLatency", 32'(n), 32'd15);
    for (int i = 0; i < 1000; i++) streamBit(1'b0, 1'b0);
    checkValue("cleanRunErrCnt", 32'(cntA), 32'd0);
    checkValue("cleanRunLock", 32'(lockA), 32'd1);

    $display("[TB] lock with in_valid toggling");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!lockA && n < 60) begin
      streamBit(1'b0, 1'b0);
      n++;
      if (!lockA) applyStimulus(1'b1, 1'b0, 1'($urandom), 1'b0);
    end
    checkValue("toggleLockLatency", 32'(n), 32'd15);

    $display("[TB] single flip and clear colliding with a flip");
    for (int i = 0; i < 5; i++) streamBit(1'b0, 1'b0);
    streamBit(1'b1, 1'b0);
    checkValue("flipErr", 32'(errA), 32'd1);
    checkValue("flipErrCnt", 32'(cntA), 32'd1);
    checkValue("flipLock", 32'(lockA), 32'd1);
    streamBit(1'b0, 1'b0);
    checkValue("flipErrPulse", 32'(errA), 32'd0);
    for (int i = 0; i < 3; i++) streamBit(1'b0, 1'b0);
    streamBit(1'b1, 1'b1);
    checkValue("clrFlipErr", 32'(errA), 32'd1);
    checkValue("clrFlipErrCnt", 32'(cntA), 32'd0);
    checkValue("clrFlipLock", 32'(lockA), 32'd1);

    $display("[TB] mid-sequence reset then all-zero stream");
    applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0);
    checkValue("midResetLock", 32'(lockA), 32'd0);
    for (int i = 0; i < 500; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkValue("zeroSeedLock", 32'(lockA), 32'd0);

    $display("[TB] eight flips inside one window");
    lockUp(n);
    for (int i = 0; i < 4; i++) streamBit(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      streamBit(1'b1, 1'b0);
      if (k < 7) begin
        streamBit(1'b0, 1'b0);
        streamBit(1'b0, 1'b0);
      end
    end
    checkValue("eightFlipErrCnt", 32'(cntA), 32'd8);
`ifdef PRBS_CHK_RESYNC_EN
    checkValue("eightFlipLock", 32'(lockA), 32'd0);
    n = 0;
    do begin
      streamBit(1'b0, 1'b0);
      n++;
    end while (!lockA && n < 60);
    checkValue("relockLatency", 32'(n), 32'd15);
    checkValue("relockErrCnt", 32'(cntA), 32'd8);
`else
    checkValue("eightFlipLock", 32'(lockA), 32'd1);
`endif

    $display("[TB] seven flips in each of three windows");
    lockUp(n);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WIN; i++) begin
        streamBit((i >= 8) && (i <= 32) && ((i % 4) == 0), 1'b0);
      end
    end
    checkValue("sevenFlipLock", 32'(lockA), 32'd1);
    checkValue("sevenFlipErrCnt", 32'(cntA), 32'd21);

    $display("[TB] saturation of the narrow counter");
    lockUp(n);
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < WIN; i++) begin
        streamBit((i >= 10) && (i <= 40) && ((i % 10) == 0), 1'b0);
      end
    end
    checkValue("satErrCntB", 32'(cntB), 32'd15);
    checkValue("satErrCntA", 32'(cntA), 32'd20);
    streamBit(1'b0, 1'b1);
    checkValue("satClrB", 32'(cntB), 32'd0);
    checkValue("satClrA", 32'(cntA), 32'd0);

    $display("[TB] randomized stream against the model");
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 299) == 0);
      r = ($urandom_range(0, 999) != 0);
      if (v) b = genStep() ^ ($urandom_range(0, 49) == 0);
      else   b = 1'($urandom);
      applyStimulus(r, v, b, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
